// File: rtl/snr_meas_pkg.sv
// ============================================================================
// Module      : snr_meas_pkg
// Description : Shared types and helpers for the SNR window meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snr_meas_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } snr_state_t;

  // Worst-case sum of 2^log2_win squares of data_w-bit samples fits this width.
  function automatic int acc_width_f(input int data_w, input int log2_win);
    return 2 * data_w + log2_win;
  endfunction

  function automatic logic signed [63:0] sat_s64(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_delay_line.sv
// ============================================================================
// Module      : sample_delay_line
// Description : DELAY-deep enabled shift register; dout is the input from
//               DELAY enabled cycles earlier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_delay_line #(
  parameter int DATA_WIDTH = 16,
  parameter int DELAY      = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout
);

  logic signed [DATA_WIDTH-1:0] r_tap [DELAY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) r_tap[i] <= '0;
    end else if (en) begin
      r_tap[0] <= din;
      for (int i = 1; i < DELAY; i++) r_tap[i] <= r_tap[i-1];
    end
  end

  assign dout = r_tap[DELAY-1];

endmodule

`default_nettype wire

// File: rtl/snr_window_meter.sv
// ============================================================================
// Module      : snr_window_meter
// Description : Aligns reference to filter latency and accumulates signal and
//               error energy over a 2^LOG2_WINDOW sample window.
//               Optional macro SNR_PEAK_EN adds the peak_err output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snr_window_meter
  import snr_meas_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_WIDTH   = 32,
  parameter int OUT_SHIFT   = 15,
  parameter int DELAY       = 64,
  parameter int LOG2_WINDOW = 10,
  parameter int ACC_WIDTH   = acc_width_f(DATA_WIDTH, LOG2_WINDOW)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] ref_in,
  input  logic signed [OUT_WIDTH-1:0]  filt_in,
  output logic                         busy,
  output logic                         done,
  output logic [ACC_WIDTH-1:0]         sig_energy,
  output logic [ACC_WIDTH-1:0]         err_energy,
  output logic                         overflow
`ifdef SNR_PEAK_EN
 ,output logic [DATA_WIDTH-2:0]        peak_err
`endif
);

  localparam int c_WIN     = 1 << LOG2_WINDOW;
  localparam int c_CNT_MAX = (DELAY > c_WIN) ? DELAY : c_WIN;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_SQ_W    = 2 * DATA_WIDTH;

  snr_state_t r_state;
  snr_state_t w_state_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic w_accept;
  logic w_clear;
  logic w_cnt_en;

  logic signed [DATA_WIDTH-1:0] w_ref_d;

  sample_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .DELAY      (DELAY)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (sample_valid),
    .din  (ref_in),
    .dout (w_ref_d)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = FILL;
      FILL:    if (sample_valid && r_cnt == c_CNT_W'(DELAY - 1)) w_state_next = ACCUM;
      ACCUM:   if (sample_valid && r_cnt == c_CNT_W'(c_WIN - 1)) w_state_next = DRAIN;
      DRAIN:   if (r_cnt == c_CNT_W'(1)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    w_accept = 1'b0;
    w_clear  = 1'b0;
    w_cnt_en = 1'b0;
    case (r_state)
      IDLE:  w_clear = start;
      FILL:  begin busy = 1'b1; w_cnt_en = sample_valid; end
      ACCUM: begin busy = 1'b1; w_cnt_en = sample_valid; w_accept = sample_valid; end
      DRAIN: begin busy = 1'b1; w_cnt_en = 1'b1; end
      DONE:  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Counter restarts on every state change, so each phase counts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (r_state != w_state_next) r_cnt <= '0;
    else if (w_cnt_en)               r_cnt <= r_cnt + c_CNT_W'(1);
  end

  // ---------------- Per-sample arithmetic ----------------
  logic signed [OUT_WIDTH-1:0]  w_filt_sh;
  logic signed [63:0]           w_y_wide;
  logic signed [63:0]           w_y_sat;
  logic signed [63:0]           w_e_wide;
  logic signed [63:0]           w_e_sat;
  logic signed [DATA_WIDTH-1:0] w_y;
  logic signed [DATA_WIDTH-1:0] w_e;
  logic                         w_sat_hit;
  logic signed [c_SQ_W-1:0]     w_ref_x;
  logic signed [c_SQ_W-1:0]     w_e_x;
  logic [c_SQ_W-1:0]            w_sig_sq;
  logic [c_SQ_W-1:0]            w_err_sq;

  always_comb begin
    w_filt_sh = filt_in >>> OUT_SHIFT;
    w_y_wide  = 64'(w_filt_sh);
    w_y_sat   = sat_s64(w_y_wide, DATA_WIDTH);
    w_y       = w_y_sat[DATA_WIDTH-1:0];
    w_e_wide  = 64'(w_y) - 64'(w_ref_d);
    w_e_sat   = sat_s64(w_e_wide, DATA_WIDTH);
    w_e       = w_e_sat[DATA_WIDTH-1:0];
    w_sat_hit = (w_y_sat != w_y_wide) || (w_e_sat != w_e_wide);
    w_ref_x   = c_SQ_W'(w_ref_d);
    w_e_x     = c_SQ_W'(w_e);
    w_sig_sq  = w_ref_x * w_ref_x;
    w_err_sq  = w_e_x * w_e_x;
  end

  // ---------------- Pipeline: squares, then accumulators ----------------
  logic                 r_sq_vld;
  logic                 r_sat;
  logic [c_SQ_W-1:0]    r_sig_sq;
  logic [c_SQ_W-1:0]    r_err_sq;
  logic [ACC_WIDTH-1:0] r_sig_acc;
  logic [ACC_WIDTH-1:0] r_err_acc;
  logic                 r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sq_vld <= 1'b0;
      r_sat    <= 1'b0;
      r_sig_sq <= '0;
      r_err_sq <= '0;
    end else begin
      r_sq_vld <= w_accept;
      r_sat    <= w_accept && w_sat_hit;
      if (w_accept) begin
        r_sig_sq <= w_sig_sq;
        r_err_sq <= w_err_sq;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig_acc <= '0;
      r_err_acc <= '0;
      r_ovf     <= 1'b0;
    end else if (w_clear) begin
      r_sig_acc <= '0;
      r_err_acc <= '0;
      r_ovf     <= 1'b0;
    end else if (r_sq_vld) begin
      r_sig_acc <= r_sig_acc + ACC_WIDTH'(r_sig_sq);
      r_err_acc <= r_err_acc + ACC_WIDTH'(r_err_sq);
      if (r_sat) r_ovf <= 1'b1;
    end
  end

  assign sig_energy = r_sig_acc;
  assign err_energy = r_err_acc;
  assign overflow   = r_ovf;

`ifdef SNR_PEAK_EN
  logic [DATA_WIDTH-2:0] w_e_mag;
  logic [DATA_WIDTH-2:0] r_e_mag;
  logic [DATA_WIDTH-2:0] r_peak;

  // The most negative error has no positive twin, so it clamps to all-ones.
  always_comb begin
    if (!w_e[DATA_WIDTH-1])               w_e_mag = w_e[DATA_WIDTH-2:0];
    else if (w_e[DATA_WIDTH-2:0] == '0)   w_e_mag = '1;
    else                                  w_e_mag = ~w_e[DATA_WIDTH-2:0] + (DATA_WIDTH-1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e_mag <= '0;
      r_peak  <= '0;
    end else begin
      if (w_accept) r_e_mag <= w_e_mag;
      if (w_clear)                              r_peak <= '0;
      else if (r_sq_vld && (r_e_mag > r_peak))  r_peak <= r_e_mag;
    end
  end

  assign peak_err = r_peak;
`endif

endmodule

`default_nettype wire
